// File: rtl/attn_scan_pkg.sv
// attn_scan_pkg: shared FSM state type and a width helper for the attention result scanner
package attn_scan_pkg;
  typedef enum logic [2:0] {IDLE, REQ, SHIFT, NEXT, DONE} scan_state_e;
  function automatic int safe_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: slot timer; O_TICK pulses on the last of every TICK_CYC enabled cycles, count clears while I_EN=0
module scan_tick_gen
  import attn_scan_pkg::*;
#(
  parameter int TICK_CYC = 268435456
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_EN,
  output logic O_TICK
);
  localparam int TW = safe_w(TICK_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TICK_CYC - 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign O_TICK = I_EN && (cnt_q == LAST);
  assign cnt_d  = (!I_EN || O_TICK) ? '0 : cnt_q + TW'(1);
  always_ff @(posedge I_CLK) cnt_q <= I_RST ? '0 : cnt_d;
endmodule

// File: rtl/attn_result_scanner.sv
// attn_result_scanner: walks the result BRAM after attention ends and serialises each word onto LANES pins (optional SCAN_PARITY_EN adds a parity slot and O_PAR_SLOT)
module attn_result_scanner
  import attn_scan_pkg::*;
#(
  parameter int MAT_W    = 4096,
  parameter int LINES    = 64,
  parameter int COLS     = 8,
  parameter int LANES    = 1,
  parameter int TICK_CYC = 268435456,
  localparam int LW = safe_w(LINES),
  localparam int CW = safe_w(COLS)
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_ATTN_END,
  input  logic             I_CONT_MODE,
  output logic             O_RD_EN,
  output logic [LW-1:0]    O_RD_LINE,
  output logic [CW-1:0]    O_RD_COL,
  input  logic             I_RD_VLD,
  input  logic [MAT_W-1:0] I_RD_MAT,
  output logic [LANES-1:0] O_SER_DATA,
  output logic             O_SER_VLD,
  output logic             O_WORD_DONE,
  output logic             O_SCAN_DONE
`ifdef SCAN_PARITY_EN
  ,output logic            O_PAR_SLOT
`endif
);
  localparam int NDATA = MAT_W / LANES;
`ifdef SCAN_PARITY_EN
  localparam int NSLOT = NDATA + 1;
`else
  localparam int NSLOT = NDATA;
`endif
  localparam int SW = safe_w(NSLOT);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOT - 1);
  scan_state_e      state_q, state_d;
  logic [LW-1:0]    line_q, line_d;
  logic [CW-1:0]    col_q, col_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [MAT_W-1:0] sh_q, sh_d;
  logic             tick, abort, col_wrap, par_slot;
  scan_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .I_CLK (I_CLK),
    .I_RST (I_RST),
    .I_EN  (state_q == SHIFT),
    .O_TICK(tick)
  );
  assign abort    = !I_ATTN_END && (state_q inside {REQ, SHIFT, NEXT});
  assign col_wrap = col_q == LAST_COL;
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE:  state_d = I_ATTN_END ? REQ : IDLE;
      REQ: if (I_RD_VLD) begin
        sh_d    = I_RD_MAT;
        slot_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: if (tick) begin
        sh_d    = sh_q >> LANES;
        slot_d  = slot_q + SW'(1);
        state_d = (slot_q == LAST_SLOT) ? NEXT : SHIFT;
      end
      NEXT: begin
        col_d   = col_wrap ? '0 : col_q + CW'(1);
        line_d  = !col_wrap ? line_q : (line_q == LAST_LINE) ? '0 : line_q + LW'(1);
        state_d = (col_wrap && line_q == LAST_LINE && !I_CONT_MODE) ? DONE : REQ;
      end
      DONE:  state_d = I_ATTN_END ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over any coincident read-valid or slot advance
    state_d = abort ? IDLE : state_d;
    line_d  = (state_d == IDLE) ? '0 : line_d;
    col_d   = (state_d == IDLE) ? '0 : col_d;
  end
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      line_q  <= '0;
      col_q   <= '0;
      slot_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
    end
  end
`ifdef SCAN_PARITY_EN
  logic par_q;
  // parity is taken from the word as captured, before any shifting
  always_ff @(posedge I_CLK) begin
    if (I_RST) par_q <= 1'b0;
    else if (state_q == REQ && I_RD_VLD) par_q <= ^I_RD_MAT;
  end
  assign par_slot   = (state_q == SHIFT) && (slot_q == SW'(NDATA));
  assign O_PAR_SLOT = par_slot;
`else
  logic par_q;
  assign par_q    = 1'b0;
  assign par_slot = 1'b0;
`endif
  assign O_RD_EN     = state_q == REQ;
  assign O_RD_LINE   = line_q;
  assign O_RD_COL    = col_q;
  assign O_SER_VLD   = state_q == SHIFT;
  assign O_SER_DATA  = !O_SER_VLD ? '0 : par_slot ? LANES'(par_q) : sh_q[LANES-1:0];
  assign O_WORD_DONE = state_q == NEXT;
  assign O_SCAN_DONE = state_q == DONE;
endmodule

// File: tb/tb_attn_result_scanner.sv
// tb_attn_result_scanner: randomized self-checking bench comparing the scanner against an address/bit-order reference model
module tb_attn_result_scanner;
  localparam int MW = 16, TC = 4;
`ifdef SCAN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clk = 0, rst = 1, attn = 0, cont = 0, vld = 0, attn4 = 0, vld4 = 0;
  logic [MW-1:0] mat = '0, mat4 = '0;
  logic rd_en, ser_vld, wdone, sdone, rd_en4, ser_vld4, wdone4, sdone4, par, par4;
  logic line, col, ser, line4, col4;
  logic [3:0] ser4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  attn_result_scanner #(.MAT_W(MW), .LINES(2), .COLS(2), .LANES(1), .TICK_CYC(TC)) u_dut (
    .I_CLK(clk), .I_RST(rst), .I_ATTN_END(attn), .I_CONT_MODE(cont),
    .O_RD_EN(rd_en), .O_RD_LINE(line), .O_RD_COL(col), .I_RD_VLD(vld), .I_RD_MAT(mat),
    .O_SER_DATA(ser), .O_SER_VLD(ser_vld), .O_WORD_DONE(wdone), .O_SCAN_DONE(sdone)
`ifdef SCAN_PARITY_EN
    , .O_PAR_SLOT(par)
`endif
  );
  attn_result_scanner #(.MAT_W(MW), .LINES(2), .COLS(2), .LANES(4), .TICK_CYC(TC)) u_dut4 (
    .I_CLK(clk), .I_RST(rst), .I_ATTN_END(attn4), .I_CONT_MODE(cont),
    .O_RD_EN(rd_en4), .O_RD_LINE(line4), .O_RD_COL(col4), .I_RD_VLD(vld4), .I_RD_MAT(mat4),
    .O_SER_DATA(ser4), .O_SER_VLD(ser_vld4), .O_WORD_DONE(wdone4), .O_SCAN_DONE(sdone4)
`ifdef SCAN_PARITY_EN
    , .O_PAR_SLOT(par4)
`endif
  );
`ifndef SCAN_PARITY_EN
  assign par = 1'b0;
  assign par4 = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Serves one BRAM request and follows the word's serial stream slot by slot.
  // cut>=0 interrupts at that slot: by reset when cut_rst, else by dropping attention-end.
  task automatic run_word(input int ln, input int cl, input logic [MW-1:0] d, input int lat,
                          input int cut, input bit cut_rst, input bit spur);
    int w = 0;
    while (!rd_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", rd_en, 1);
    if (!rd_en) return;
    check("req_line", line, ln);
    check("req_col", col, cl);
    check("req_scan_done", sdone, 0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("req_hold", {rd_en, line, col}, {1'b1, 1'(ln), 1'(cl)});
    end
    vld = 1;
    mat = d;
    for (int k = 0; k < MW + PAR; k++) begin
      for (int c = 0; c < TC; c++) begin
        @(negedge clk);
        vld = 0;
        check("ser_vld", ser_vld, 1);
        check("ser_data", ser, (k < MW) ? d[k] : ^d);
        check("par_slot", par, (PAR != 0) && (k == MW));
        check("rd_en_low", rd_en, 0);
        if (spur && k == 2 && c == 1) begin
          vld = 1;
          mat = ~d;
        end
        if (k == cut && c == 1) begin
          if (cut_rst) rst = 1; else attn = 0;
          @(negedge clk);
          rst = 0;
          check("cut_outputs", {rd_en, ser_vld, ser, wdone, sdone, line, col, par}, 0);
          return;
        end
      end
    end
    @(negedge clk);
    vld = 0;
    check("word_done", {wdone, ser_vld, ser}, {1'b1, 1'b0, 1'b0});
  endtask
  initial begin
    int idx = 0;
    logic [MW-1:0] d;
    repeat (3) @(negedge clk);
    check("rst_out", {rd_en, ser_vld, ser, wdone, sdone, line, col, par}, 0);
    check("rst_out4", {rd_en4, ser_vld4, ser4, wdone4, sdone4, line4, col4, par4}, 0);
    rst = 0;
    // single pass, first word fixes the bit order, fixed 3-cycle read latency
    attn = 1;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 16'hA5C3 : 16'($urandom);
      run_word(i / 2, i % 2, d, 3, -1, 0, i == 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("scan_done", {sdone, rd_en, wdone, ser_vld}, 4'b1000);
    end
    attn = 0;
    @(negedge clk);
    check("done_exit", {sdone, rd_en, line, col}, 0);
    // continuous mode: wraps back to (0,0), random latencies
    cont = 1;
    attn = 1;
    for (idx = 0; idx < 5; idx++) run_word((idx / 2) % 2, idx % 2, 16'($urandom), $urandom_range(0, 5), -1, 0, 0);
    // abort during slot 5 of word (0,1)
    run_word(0, 1, 16'($urandom), 2, 5, 0, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_idle", {rd_en, ser_vld, wdone, sdone}, 0);
    end
    cont = 0;
    attn = 1;
    @(negedge clk);
    run_word(0, 0, 16'($urandom), 1, 3, 1, 0);
    run_word(0, 0, 16'($urandom), 0, -1, 0, 0);
    run_word(0, 1, 16'($urandom), 4, -1, 0, 0);
    attn = 0;
    @(negedge clk);
    check("abort_next", {rd_en, ser_vld, sdone}, 0);
    // four lanes: 16'h1234 leaves as nibbles 4,3,2,1
    attn4 = 1;
    begin
      int w = 0;
      while (!rd_en4 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("l4_req", {rd_en4, line4, col4}, 3'b100);
      vld4 = 1;
      mat4 = 16'h1234;
      for (int k = 0; k < 4 + PAR; k++) begin
        for (int c = 0; c < TC; c++) begin
          @(negedge clk);
          vld4 = 0;
          check("l4_data", {ser_vld4, ser4}, {1'b1, (k < 4) ? 4'(16'h1234 >> (4 * k)) : 4'(^16'h1234)});
          check("l4_par", par4, (PAR != 0) && (k == 4));
        end
      end
      @(negedge clk);
      check("l4_word_done", {wdone4, ser_vld4, ser4}, 6'b100000);
      attn4 = 0;
      @(negedge clk);
      check("l4_abort", {rd_en4, ser_vld4, wdone4}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
